// File: rtl/sram_port_ctrl_pkg.sv
// Shared helpers for the SRAM port controller: width function, FIFO op
// encoding and the response entry layout {err, rdata}.
package sram_port_ctrl_pkg;

  // Response entry layout: bit RSP_ERR_BIT(dw) is err, bits [dw-1:0] are rdata
  function automatic int unsigned rsp_entry_width(input int unsigned dw);
    return dw + 1;
  endfunction

  // Number of bits needed to represent value (0 -> 0 bits)
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned bits;
    v    = value;
    bits = 0;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return bits;
  endfunction

  typedef enum logic [1:0] {
    FIFO_HOLD = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// In-order response queue with occupancy count; head reads as 0 when empty.
module sram_rsp_fifo
  import sram_port_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = 2
) (
  input  logic             clka,
  input  logic             rsta,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = (clogb2(DEPTH - 1) < 1) ? 1 : clogb2(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  fifo_op_e         op;

  assign op = fifo_op_e'({push, pop});

  // Storage array; contents are only observed through a valid count
  always_ff @(posedge clka) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers and count, wrapping at DEPTH
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case (op)
        FIFO_PUSH: count <= count + CW'(1);
        FIFO_POP:  count <= count - CW'(1);
        default:   count <= count;
      endcase
    end
  end

  // Head entry, forced to 0 while empty
  always_comb begin
    pop_data = '0;
    if (count != '0) pop_data = mem[rd_ptr];
  end

endmodule

// File: rtl/sram_port_ctrl.sv
// Initiator side of a single-port byte-write SRAM: turns a valid/ready
// request channel into SRAM strobes and queues the registered read data.
// Optional out-of-range checking: define SRAM_PORT_CTRL_RANGE_CHECK_EN.
module sram_port_ctrl
  import sram_port_ctrl_pkg::*;
#(
  parameter int unsigned NB_COL    = 4,
  parameter int unsigned COL_WIDTH = 8,
  parameter int unsigned RAM_DEPTH = 8192,
  parameter int unsigned REQ_AW    = 32,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic                                 clka,
  input  logic                                 rsta,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [REQ_AW-1:0]                    req_addr,
  input  logic [NB_COL*COL_WIDTH-1:0]          req_wdata,
  input  logic [NB_COL-1:0]                    req_wstrb,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [NB_COL*COL_WIDTH-1:0]          rsp_rdata,
  output logic                                 rsp_err,
  output logic                                 sram_en,
  output logic [NB_COL-1:0]                    sram_we,
  output logic [clogb2(RAM_DEPTH-1)-1:0]       sram_addr,
  output logic [NB_COL*COL_WIDTH-1:0]          sram_din,
  input  logic [NB_COL*COL_WIDTH-1:0]          sram_dout
);

  localparam int unsigned DW    = NB_COL * COL_WIDTH;
  localparam int unsigned EW    = rsp_entry_width(DW);
  localparam int unsigned OFF_W = clogb2(NB_COL - 1);
  localparam int unsigned AW    = clogb2(RAM_DEPTH - 1);
  localparam int unsigned CW    = clogb2(RSP_DEPTH);

  logic          accept;
  logic          pop;
  logic          range_err;
  logic          infl_q;
  logic          infl_read_q;
  logic          infl_err_q;
  logic [AW-1:0] word;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic [EW-1:0] push_data;
  logic [EW-1:0] head;
  logic          unused_addr_bits;

  assign word   = req_addr[OFF_W +: AW];
  assign accept = req_valid & req_ready;
  assign pop    = rsp_valid & rsp_ready;

`ifdef SRAM_PORT_CTRL_RANGE_CHECK_EN
  // Flag words past the array or any address bit above the word field
  always_comb begin
    range_err = 1'b0;
    if (req_addr[REQ_AW-1:OFF_W+AW] != '0) range_err = 1'b1;
    if ({1'b0, word} >= (AW+1)'(RAM_DEPTH)) range_err = 1'b1;
  end
  assign unused_addr_bits = ^req_addr[OFF_W-1:0];
`else
  assign range_err        = 1'b0;
  assign unused_addr_bits = ^{req_addr[REQ_AW-1:OFF_W+AW], req_addr[OFF_W-1:0]};
`endif

  // Credit: queued + in-flight, less this cycle's pop, must leave a free slot
  always_comb begin
    occ       = (CW+1)'(count) + (CW+1)'(infl_q) - (CW+1)'(pop);
    req_ready = ~rsta & (occ < (CW+1)'(RSP_DEPTH));
  end

  // SRAM strobes straight from the accepted request
  always_comb begin
    sram_en   = accept & ~range_err;
    sram_we   = '0;
    sram_addr = word;
    sram_din  = req_wdata;
    if (sram_en) sram_we = req_wstrb;
  end

  // Track the access whose read data arrives next cycle
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      infl_q      <= 1'b0;
      infl_read_q <= 1'b0;
      infl_err_q  <= 1'b0;
    end else begin
      infl_q      <= accept;
      infl_read_q <= (req_wstrb == '0);
      infl_err_q  <= range_err;
    end
  end

  // Response entry: read data only for good reads, else zero
  always_comb begin
    push_data = '0;
    push_data[DW] = infl_err_q;
    if (infl_read_q && !infl_err_q) push_data[DW-1:0] = sram_dout;
  end

  sram_rsp_fifo #(
    .WIDTH (EW),
    .DEPTH (RSP_DEPTH),
    .CW    (CW)
  ) u_rsp_fifo (
    .clka      (clka),
    .rsta      (rsta),
    .push      (infl_q),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .count     (count)
  );

  assign rsp_valid = (count != '0);
  assign rsp_err   = head[DW];
  assign rsp_rdata = head[DW-1:0];

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Self-checking bench for sram_port_ctrl with a behavioural SRAM and an
// in-order response scoreboard.
module tb_sram_port_ctrl;

  logic        clka = 1'b0;
  logic        rsta;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [12:0] sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;

  logic [31:0] sram_mem [0:8191];
  logic [31:0] ref_mem  [0:8191];
  logic [32:0] exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          pop_cnt  = 0;

  always #5 clka = ~clka;

  sram_port_ctrl dut (
    .clka      (clka),
    .rsta      (rsta),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  // Behavioural SRAM: byte writes, registered read-first data, 0 when idle
  always @(posedge clka) begin
    if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) sram_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      sram_dout <= sram_mem[sram_addr];
    end else begin
      sram_dout <= 32'h0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Response monitor: head must match scoreboard every valid cycle
  always @(negedge clka) begin
    if (!rsta) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_spurious", 64'(rsp_valid), 64'(0));
      end else if (rsp_valid) begin
        check_eq("rsp_data", 64'({rsp_err, rsp_rdata}), 64'(exp_q[0]));
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          pop_cnt++;
        end
      end
    end
  end

  task automatic sync();
    @(posedge clka);
    #1;
  endtask

  // Issue one request; checks strobes at the accept cycle and queues expectation
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output int waits);
    logic [12:0] w;
    logic        oor;
    w   = addr[14:2];
`ifdef SRAM_PORT_CTRL_RANGE_CHECK_EN
    oor = (addr[31:15] != 17'h0);
`else
    oor = 1'b0;
`endif
    req_valid = 1'b1;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    waits     = 0;
    @(negedge clka);
    while (!req_ready && waits < 20) begin
      waits++;
      @(negedge clka);
    end
    check_eq("req_accept", 64'(req_ready), 64'(1));
    if (req_ready) begin
      check_eq("sram_en", 64'(sram_en), 64'(!oor));
      check_eq("sram_we", 64'(sram_we), oor ? 64'(0) : 64'(wstrb));
      if (!oor) begin
        check_eq("sram_addr", 64'(sram_addr), 64'(w));
        if (wstrb != 4'h0) check_eq("sram_din", 64'(sram_din), 64'(wdata));
      end
      if (oor) begin
        exp_q.push_back({1'b1, 32'h0});
      end else if (wstrb != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
        exp_q.push_back({1'b0, 32'h0});
      end else begin
        exp_q.push_back({1'b0, ref_mem[w]});
      end
    end
    @(posedge clka);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clka);
      n++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'(0));
    sync();
  endtask

  // Read with an empty queue: valid must appear exactly two cycles after accept
  task automatic read_latency(input logic [31:0] addr);
    int w;
    do_req(addr, 32'h0, 4'h0, w);
    @(negedge clka);
    check_eq("lat_t1", 64'(rsp_valid), 64'(0));
    @(negedge clka);
    check_eq("lat_t2", 64'(rsp_valid), 64'(1));
    wait_drain();
  endtask

  task automatic check_idle_reset(input string tag);
    check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check_eq({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check_eq({tag, "_sram_en"},   64'(sram_en),   64'(0));
    check_eq({tag, "_sram_we"},   64'(sram_we),   64'(0));
    check_eq({tag, "_rdata"},     64'(rsp_rdata), 64'(0));
    check_eq({tag, "_err"},       64'(rsp_err),   64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int w;
    for (int i = 0; i < 8192; i++) begin
      sram_mem[i] = 32'h0;
      ref_mem[i]  = 32'h0;
    end
    rsta      = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_wstrb = 4'h0;
    rsp_ready = 1'b1;
    sram_dout = 32'h0;
    req_valid = 1'b1;
    repeat (2) @(negedge clka);
    check_idle_reset("reset");
    req_valid = 1'b0;
    sync();
    rsta = 1'b0;
    sync();

    // Full write then read with latency check; partial-lane write
    do_req(32'h10, 32'h11223344, 4'hF, w);
    wait_drain();
    read_latency(32'h10);
    do_req(32'h10, 32'hAABBCCDD, 4'b0100, w);
    wait_drain();
    read_latency(32'h10);

    // Eight back-to-back reads with the consumer always ready
    for (int i = 0; i < 8; i++)
      do_req(32'h100 + 32'(4*i), 32'hA0000000 + 32'(i) * 32'h01010101, 4'hF, w);
    wait_drain();
    begin
      int base;
      base = pop_cnt;
      for (int i = 0; i < 8; i++) begin
        do_req(32'h100 + 32'(4*i), 32'h0, 4'h0, w);
        check_eq("b2b_waits", 64'(w), 64'(0));
      end
      repeat (2) @(negedge clka);
      #1;
      check_eq("b2b_pops", 64'(pop_cnt), 64'(base + 8));
    end
    wait_drain();

    // Back-pressure: exactly RSP_DEPTH accepts, then stall with stable head
    rsp_ready = 1'b0;
    do_req(32'h104, 32'h0, 4'h0, w);
    check_eq("bp_first_waits", 64'(w), 64'(0));
    do_req(32'h108, 32'h0, 4'h0, w);
    check_eq("bp_second_waits", 64'(w), 64'(0));
    req_valid = 1'b1;
    req_addr  = 32'h10C;
    req_wstrb = 4'h0;
    repeat (4) begin
      @(negedge clka);
      check_eq("bp_full_ready", 64'(req_ready), 64'(0));
      check_eq("bp_full_en",    64'(sram_en),   64'(0));
      check_eq("bp_head",       64'(rsp_rdata), 64'(32'hA1010101));
    end
    sync();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_drain();

    // Reset while a read is in flight: its response is dropped
    do_req(32'h10, 32'h0, 4'h0, w);
    #2;
    rsta = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clka);
    check_idle_reset("midrst");
    @(posedge clka);
    #2;
    rsta = 1'b0;
    repeat (3) begin
      @(negedge clka);
      check_eq("post_rst_quiet", 64'(rsp_valid), 64'(0));
    end
    sync();
    read_latency(32'h10);

    // Address past the array: error response or wrap to word 0
    do_req(32'h0, 32'hCAFEF00D, 4'hF, w);
    wait_drain();
    do_req(32'h8000, 32'h0, 4'h0, w);
    wait_drain();
    read_latency(32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
